// File: rtl/frame_pixel_source_pkg.sv
// Shared image-pipeline definitions: FSM encodings and frame address sizing.
package frame_pixel_source_pkg;

    localparam int FRAME_PIXELS = 640 * 480;
    localparam int ADDR_W       = $clog2(FRAME_PIXELS);
    localparam int COORD_W      = 13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_DONE   = 2'd3
    } fps_state_t;

endpackage

// File: rtl/frame_pixel_source_raster_counter.sv
// Raster walker: row/col position plus a linear word address that runs on
// across rows, so no row*LINES multiply is needed.
module raster_counter
    import frame_pixel_source_pkg::*;
#(
    parameter int LINES = 640,
    parameter int ROWS  = 480
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_adv,
    output logic [COORD_W-1:0] o_row,
    output logic [COORD_W-1:0] o_col,
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_eol,
    output logic               o_last_row
);

    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] r_col;
    logic [ADDR_W-1:0]  r_addr;
    logic               w_eol;

    assign w_eol      = (r_col == COORD_W'(LINES - 1));
    assign o_eol      = w_eol;
    assign o_last_row = (r_row == COORD_W'(ROWS - 1));
    assign o_row      = r_row;
    assign o_col      = r_col;
    assign o_addr     = r_addr;

    always_ff @(posedge clk) begin
        if (i_rst || i_clr) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (i_adv) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (w_eol) begin
                r_col <= '0;
                r_row <= r_row + COORD_W'(1);
            end else begin
                r_col <= r_col + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_pixel_source.sv
// Streams one frame from pixel memory into the processing pipeline,
// with optional horizontal blanking and a pause that stalls memory reads.
module frame_pixel_source
    import frame_pixel_source_pkg::*;
#(
    parameter int LINES       = 640,
    parameter int ROWS        = 480,
    parameter int PIXEL_DEPTH = 8,
    parameter int HBLANK      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pause,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [3*PIXEL_DEPTH-1:0] mem_rdata,
    output logic [PIXEL_DEPTH-1:0]   raw_VGA_R,
    output logic [PIXEL_DEPTH-1:0]   raw_VGA_G,
    output logic [PIXEL_DEPTH-1:0]   raw_VGA_B,
    output logic [COORD_W-1:0]       row,
    output logic [COORD_W-1:0]       col,
    output logic                     valid_o,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int HB_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;

    fps_state_t               r_state;
    logic [HB_W-1:0]          r_hb;
    logic                     r_frame_done;
    logic                     r_valid;
    logic [COORD_W-1:0]       r_row;
    logic [COORD_W-1:0]       r_col;
    logic [3*PIXEL_DEPTH-1:0] r_pix;

    logic                     w_rd;
    logic                     w_clr;
    logic                     w_eol;
    logic                     w_last_row;
    logic [COORD_W-1:0]       w_cnt_row;
    logic [COORD_W-1:0]       w_cnt_col;
    logic [ADDR_W-1:0]        w_cnt_addr;
    logic [3*PIXEL_DEPTH-1:0] w_pix;

    assign w_rd  = (r_state == ST_ACTIVE) && !pause;
    assign w_clr = (r_state == ST_IDLE) && start;

    raster_counter #(
        .LINES (LINES),
        .ROWS  (ROWS)
    ) u_cnt (
        .clk        (clk),
        .i_rst      (reset),
        .i_clr      (w_clr),
        .i_adv      (w_rd),
        .o_row      (w_cnt_row),
        .o_col      (w_cnt_col),
        .o_addr     (w_cnt_addr),
        .o_eol      (w_eol),
        .o_last_row (w_last_row)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_hb         <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (w_rd && w_eol) begin
                        if (w_last_row) begin
                            r_state      <= ST_DONE;
                            r_frame_done <= 1'b1;
                        end else if (HBLANK != 0) begin
                            r_state <= ST_HBLANK;
                            r_hb    <= '0;
                        end
                    end
                end
                ST_HBLANK: begin
                    if (r_hb == HB_W'(HBLANK - 1)) r_state <= ST_ACTIVE;
                    else r_hb <= r_hb + HB_W'(1);
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data lands one cycle after mem_rd, aligned with valid_o.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_pix   <= '0;
        end else begin
            r_valid <= w_rd;
            if (w_rd) begin
                r_row <= w_cnt_row;
                r_col <= w_cnt_col;
            end
            if (r_valid) r_pix <= mem_rdata;
        end
    end

    assign w_pix      = r_valid ? mem_rdata : r_pix;
    assign raw_VGA_R  = w_pix[3*PIXEL_DEPTH-1:2*PIXEL_DEPTH];
    assign raw_VGA_G  = w_pix[2*PIXEL_DEPTH-1:PIXEL_DEPTH];
    assign raw_VGA_B  = w_pix[PIXEL_DEPTH-1:0];
    assign mem_rd     = w_rd;
    assign mem_addr   = w_cnt_addr;
    assign row        = r_row;
    assign col        = r_col;
    assign valid_o    = r_valid;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_frame_pixel_source.sv
// Two small-frame instances (HBLANK=2 and HBLANK=0) checked every cycle
// against a pixel-index model, plus literal timing expectations.
module tb_frame_pixel_source;

    localparam int L = 4;
    localparam int R = 3;
    localparam int T = L * R;
    localparam int HBV [2] = '{2, 0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;

    logic        rd   [2];
    logic [18:0] addr [2];
    logic [23:0] mq   [2];
    logic [7:0]  vr   [2];
    logic [7:0]  vg   [2];
    logic [7:0]  vb   [2];
    logic [12:0] orow [2];
    logic [12:0] ocol [2];
    logic        vld  [2];
    logic        bsy  [2];
    logic        fd   [2];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    bit armed = 1'b0;

    int m_busy [2] = '{0, 0};
    int m_done [2] = '{0, 0};
    int m_blank[2] = '{0, 0};
    int m_n    [2] = '{0, 0};
    int m_prev [2] = '{-1, -1};
    int m_hrow [2] = '{0, 0};
    int m_hcol [2] = '{0, 0};
    int m_hpix [2] = '{0, 0};

    int lg_rd [2][64];
    int lg_a  [2][64];
    int lg_v  [2][64];
    int lg_d  [2][64];
    int lg_row[2][64];
    int lg_col[2][64];
    int lg_fd [2][64];
    int lg_b  [2][64];

    frame_pixel_source #(
        .LINES(L), .ROWS(R), .PIXEL_DEPTH(8), .HBLANK(2)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .mem_rd(rd[0]), .mem_addr(addr[0]), .mem_rdata(mq[0]),
        .raw_VGA_R(vr[0]), .raw_VGA_G(vg[0]), .raw_VGA_B(vb[0]),
        .row(orow[0]), .col(ocol[0]), .valid_o(vld[0]),
        .busy(bsy[0]), .frame_done(fd[0])
    );

    frame_pixel_source #(
        .LINES(L), .ROWS(R), .PIXEL_DEPTH(8), .HBLANK(0)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .mem_rd(rd[1]), .mem_addr(addr[1]), .mem_rdata(mq[1]),
        .raw_VGA_R(vr[1]), .raw_VGA_G(vg[1]), .raw_VGA_B(vb[1]),
        .row(orow[1]), .col(ocol[1]), .valid_o(vld[1]),
        .busy(bsy[1]), .frame_done(fd[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns its address; junk when no read so holds are visible.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            mq[k] <= rd[k] ? 24'(addr[k]) : (24'hC0FFEE ^ 24'(cyc));
    end

    task automatic chk(input string nm, input int k,
                       input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0d want=%0d t=%0t",
                     nm, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int er, ev, erow, ecol, epix, idx;
        for (int k = 0; k < 2; k++) begin
            er = (m_busy[k] != 0 && m_done[k] == 0 &&
                  m_blank[k] == 0 && !pause) ? 1 : 0;
            ev = (m_prev[k] >= 0) ? 1 : 0;
            if (ev != 0) begin
                erow = m_prev[k] / L;
                ecol = m_prev[k] % L;
                epix = m_prev[k];
            end else begin
                erow = m_hrow[k];
                ecol = m_hcol[k];
                epix = m_hpix[k];
            end
            if (armed) begin
                chk("mem_rd", k, longint'(rd[k]), er);
                if (er != 0) chk("mem_addr", k, longint'(addr[k]), m_n[k]);
                chk("valid_o", k, longint'(vld[k]), ev);
                chk("row", k, longint'(orow[k]), erow);
                chk("col", k, longint'(ocol[k]), ecol);
                chk("pixel", k, longint'({vr[k], vg[k], vb[k]}), epix);
                chk("busy", k, longint'(bsy[k]), m_busy[k]);
                chk("frame_done", k, longint'(fd[k]), m_done[k]);
                idx = cyc - t0;
                if (idx >= 0 && idx < 64) begin
                    lg_rd[k][idx]  = int'(rd[k]);
                    lg_a[k][idx]   = int'(addr[k]);
                    lg_v[k][idx]   = int'(vld[k]);
                    lg_d[k][idx]   = int'({vr[k], vg[k], vb[k]});
                    lg_row[k][idx] = int'(orow[k]);
                    lg_col[k][idx] = int'(ocol[k]);
                    lg_fd[k][idx]  = int'(fd[k]);
                    lg_b[k][idx]   = int'(bsy[k]);
                end
            end
            if (reset) begin
                m_busy[k] = 0; m_done[k] = 0; m_blank[k] = 0;
                m_n[k] = 0; m_prev[k] = -1;
                m_hrow[k] = 0; m_hcol[k] = 0; m_hpix[k] = 0;
            end else begin
                if (ev != 0) begin
                    m_hrow[k] = erow; m_hcol[k] = ecol; m_hpix[k] = epix;
                end
                m_prev[k] = (er != 0) ? m_n[k] : -1;
                if (m_done[k] != 0) begin
                    m_done[k] = 0;
                    m_busy[k] = 0;
                end else if (m_busy[k] == 0) begin
                    if (start) begin
                        m_busy[k] = 1; m_n[k] = 0; m_blank[k] = 0;
                    end
                end else if (m_blank[k] > 0) begin
                    m_blank[k]--;
                end else if (er != 0) begin
                    m_n[k]++;
                    if (m_n[k] == T) m_done[k] = 1;
                    else if (m_n[k] % L == 0) m_blank[k] = HBV[k];
                end
            end
        end
        if (reset) armed = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_c(input int c);
        while (cyc - t0 < c) tick();
    endtask

    task automatic new_frame();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++) begin
                lg_rd[k][i] = 0; lg_a[k][i] = 0; lg_v[k][i] = 0;
                lg_d[k][i] = 0; lg_row[k][i] = 0; lg_col[k][i] = 0;
                lg_fd[k][i] = 0; lg_b[k][i] = 0;
            end
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic scan(input int k, input string nm,
                        input int want_pix, input int want_fd);
        int j, f;
        j = 0;
        f = 0;
        for (int c = 0; c < 64; c++) begin
            if (lg_v[k][c] != 0) begin
                chk({nm, "_order"}, k, lg_d[k][c], j);
                j++;
            end
            if (lg_fd[k][c] != 0) f++;
        end
        chk({nm, "_pixels"}, k, j, want_pix);
        chk({nm, "_frame_done"}, k, f, want_fd);
    endtask

    initial begin
        int ev2 [6];
        ev2 = '{1, 1, 0, 0, 0, 1};

        // Reset, with start asserted alongside it on the last reset edge.
        reset = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        tick();
        chk("rst_busy", 0, longint'(bsy[0]), 0);
        chk("rst_valid", 0, longint'(vld[0]), 0);
        chk("rst_mem_rd", 0, longint'(rd[0]), 0);
        chk("rst_addr", 0, longint'(addr[0]), 0);
        chk("rst_pixel", 0, longint'({vr[0], vg[0], vb[0]}), 0);
        chk("rst_busy", 1, longint'(bsy[1]), 0);

        // Plain frame.
        new_frame();
        goto_c(30);
        for (int c = 0; c < 20; c++)
            chk("s1_rd_cycle", 0, lg_rd[0][c],
                ((c >= 1 && c <= 4) || (c >= 7 && c <= 10) ||
                 (c >= 13 && c <= 16)) ? 1 : 0);
        chk("s1_fd_c17", 0, lg_fd[0][17], 1);
        chk("s1_row_c17", 0, lg_row[0][17], 2);
        chk("s1_col_c17", 0, lg_col[0][17], 3);
        chk("s1_data_c17", 0, lg_d[0][17], 11);
        chk("s1_busy_c17", 0, lg_b[0][17], 1);
        chk("s1_busy_c18", 0, lg_b[0][18], 0);
        for (int c = 0; c < 16; c++)
            chk("s1_rd_cycle", 1, lg_rd[1][c], (c >= 1 && c <= 12) ? 1 : 0);
        chk("s1_fd_c13", 1, lg_fd[1][13], 1);
        scan(0, "s1", 12, 1);
        scan(1, "s1", 12, 1);

        // Pause while col 2 of row 0 is next.
        new_frame();
        goto_c(3);
        pause = 1'b1;
        goto_c(6);
        pause = 1'b0;
        goto_c(30);
        for (int c = 0; c < 6; c++)
            chk("s2_valid", 0, lg_v[0][c + 2], ev2[c]);
        chk("s2_data_c3", 0, lg_d[0][3], 1);
        chk("s2_data_c7", 0, lg_d[0][7], 2);
        scan(0, "s2", 12, 1);
        scan(1, "s2", 12, 1);

        // Start re-pulsed mid-frame and in DONE.
        new_frame();
        goto_c(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        goto_c(17);
        start = 1'b1;
        tick();
        start = 1'b0;
        goto_c(40);
        chk("s3_busy_c18", 0, lg_b[0][18], 0);
        scan(0, "s3", 12, 1);

        // Reset during the read of data 6, then a fresh frame.
        new_frame();
        goto_c(9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        goto_c(12);
        chk("s4_rd_c9", 0, lg_rd[0][9], 1);
        chk("s4_addr_c9", 0, lg_a[0][9], 6);
        chk("s4_valid_c10", 0, lg_v[0][10], 0);
        new_frame();
        goto_c(30);
        chk("s4_valid_c1", 0, lg_v[0][1], 0);
        chk("s4_valid_c2", 0, lg_v[0][2], 1);
        chk("s4_data_c2", 0, lg_d[0][2], 0);
        chk("s4_row_c2", 0, lg_row[0][2], 0);
        chk("s4_col_c2", 0, lg_col[0][2], 0);
        scan(0, "s4", 12, 1);
        scan(1, "s4", 12, 1);

        // Pause covering the row-0 blank and one cycle past it.
        new_frame();
        goto_c(5);
        pause = 1'b1;
        goto_c(8);
        pause = 1'b0;
        goto_c(30);
        for (int c = 5; c < 8; c++)
            chk("s5_rd_paused", 0, lg_rd[0][c], 0);
        chk("s5_rd_c8", 0, lg_rd[0][8], 1);
        chk("s5_addr_c8", 0, lg_a[0][8], 4);
        scan(0, "s5", 12, 1);
        scan(1, "s5", 12, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
